uart_response_arbiter: RTL and testbench

Shares one UART output handler among NUM_REQ response producers (e.g. wishbone master replies, interrupt notices). It arbitrates round-robin between pending requesters and latches the winner's status/address/data packet. It then launches the packet into the handler with a valid/ready handshake and holds ownership until the handler reports `finished` or a watchdog expires. The block sits between the master-handler response sources and the UART output handler.

---
 rtl/uart_response_arbiter_pkg.sv | 6 +
 rtl/uart_response_arbiter_rr_priority_picker.sv | 20 ++
 rtl/uart_response_arbiter.sv | 114 +++++++++++
 tb/tb_uart_response_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_response_arbiter_pkg.sv
// uart_response_arbiter_pkg: shared state encodings, packet width and default watchdog limit
package uart_response_arbiter_pkg;
  localparam int PKT_W = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 200000;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_DONE = 2'd2} state_e;
endpackage

// File: rtl/uart_response_arbiter_rr_priority_picker.sv
// rr_priority_picker: round-robin winner search starting just above last_grant
module rr_priority_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         last_grant_i,
  output logic               any_o,
  output logic [2:0]         winner_o
);
  logic [NUM_REQ-1:0] rot;
  int off;
  // Rotating a doubled copy puts the highest-priority requester at bit 0
  always_comb begin
    rot = NUM_REQ'({req_i, req_i} >> (int'(last_grant_i) + 1));
    any_o = |req_i;
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = k;
    winner_o = 3'((int'(last_grant_i) + 1 + off) % NUM_REQ);
  end
endmodule

// File: rtl/uart_response_arbiter.sv
// uart_response_arbiter: round-robin sharing of one UART output handler with launch handshake and watchdog
module uart_response_arbiter
  import uart_response_arbiter_pkg::*;
#(
  parameter int          NUM_REQ = 2,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [PKT_W*NUM_REQ-1:0] req_status,
  input  logic [PKT_W*NUM_REQ-1:0] req_address,
  input  logic [PKT_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [PKT_W-1:0]         status,
  output logic [PKT_W-1:0]         address,
  output logic [PKT_W-1:0]         data,
  output logic                     send_en,
  input  logic                     handler_ready,
  input  logic                     finished,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     timeout
);
  state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0] last_q, last_d, grant_q, grant_d, win;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [PKT_W-1:0] status_q, status_d, address_q, address_d, data_q, data_d;
  logic send_q, send_d, to_q, to_d, any, expired;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i       (req_valid),
    .last_grant_i(last_q),
    .any_o       (any),
    .winner_o    (win)
  );

  assign expired = (TIMEOUT != 0) && (timer_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d = last_q;
    grant_d = grant_q;
    ack_d = '0;
    status_d = status_q;
    address_d = address_q;
    data_d = data_q;
    send_d = send_q;
    to_d = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        status_d = req_status[int'(win)*PKT_W +: PKT_W];
        address_d = req_address[int'(win)*PKT_W +: PKT_W];
        data_d = req_data[int'(win)*PKT_W +: PKT_W];
        ack_d = NUM_REQ'(1) << win;
        grant_d = win;
        send_d = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: if (handler_ready) begin
        send_d = 1'b0;
        timer_d = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        timer_d = &timer_q ? timer_q : timer_q + 32'd1;
        // finished takes precedence over a coincident watchdog expiry
        if (finished || expired) begin
          last_d = grant_q;
          to_d = !finished;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q <= 3'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q <= '0;
      status_q <= '0;
      address_q <= '0;
      data_q <= '0;
      send_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q <= last_d;
      grant_q <= grant_d;
      ack_q <= ack_d;
      status_q <= status_d;
      address_q <= address_d;
      data_q <= data_d;
      send_q <= send_d;
      to_q <= to_d;
    end
  end

  assign req_ack = ack_q;
  assign status = status_q;
  assign address = address_q;
  assign data = data_q;
  assign send_en = send_q;
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_uart_response_arbiter.sv
// tb_uart_response_arbiter: directed plan scenarios plus random traffic against a per-cycle reference model
module tb_uart_response_arbiter;
  localparam int N = 2;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [32*N-1:0] req_status = '0, req_address = '0, req_data = '0;
  logic handler_ready = 1'b0, finished = 1'b0;
  logic [N-1:0] req_ack;
  logic [31:0] status, address, data;
  logic send_en, busy, timeout;
  logic [2:0] grant_id;

  uart_response_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_status(req_status),
    .req_address(req_address), .req_data(req_data), .req_ack(req_ack),
    .status(status), .address(address), .data(data), .send_en(send_en),
    .handler_ready(handler_ready), .finished(finished), .busy(busy),
    .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // mode: 0 idle, 1 launching, 2 waiting for the handler; waited counts completed wait cycles
  int mode = 0, m_last = N - 1, m_gid = 0, waited = 0;
  logic [N-1:0] m_ack = '0;
  logic [31:0] m_st = '0, m_ad = '0, m_da = '0;
  logic m_send = 1'b0, m_to = 1'b0;
  logic s_rst, s_ready, s_fin;
  logic [N-1:0] s_req;
  logic [32*N-1:0] s_st, s_ad, s_da;
  bit keep = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_words(input int i);
    req_status[32*i +: 32] = $urandom;
    req_address[32*i +: 32] = $urandom;
    req_data[32*i +: 32] = $urandom;
  endtask

  task automatic model_step();
    int w;
    bit found;
    m_ack = '0;
    m_to = 1'b0;
    if (s_rst) begin
      mode = 0; m_last = N - 1; m_gid = 0; m_st = '0; m_ad = '0; m_da = '0; m_send = 1'b0;
    end else if (mode == 0) begin
      found = 0; w = 0;
      for (int k = 1; k <= N; k++)
        if (!found && s_req[(m_last + k) % N]) begin found = 1; w = (m_last + k) % N; end
      if (found) begin
        m_st = s_st[32*w +: 32]; m_ad = s_ad[32*w +: 32]; m_da = s_da[32*w +: 32];
        m_ack[w] = 1'b1; m_gid = w; m_send = 1'b1; mode = 1;
      end
    end else if (mode == 1) begin
      if (s_ready) begin m_send = 1'b0; mode = 2; waited = 0; end
    end else begin
      if (s_fin) begin m_last = m_gid; mode = 0; end
      else if (waited == TO - 1) begin m_to = 1'b1; m_last = m_gid; mode = 0; end
      else waited++;
    end
  endtask

  task automatic cycle();
    s_rst = rst; s_req = req_valid; s_ready = handler_ready; s_fin = finished;
    s_st = req_status; s_ad = req_address; s_da = req_data;
    @(posedge clk);
    model_step();
    #1;
    check("ack", 32'(req_ack), 32'(m_ack));
    check("status", status, m_st);
    check("address", address, m_ad);
    check("data", data, m_da);
    check("send_en", 32'(send_en), 32'(m_send));
    check("busy", 32'(busy), 32'(mode != 0));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("timeout", 32'(timeout), 32'(m_to));
    for (int i = 0; i < N; i++)
      if (m_ack[i]) begin
        if (keep) set_words(i);
        else req_valid[i] = 1'b0;
      end
  endtask

  initial begin
    int order[8];
    int np, done, c0, c1;
    logic [31:0] held;
    cycle(); cycle();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 0);
    rst = 1'b0;
    // single request
    req_status[31:0] = 32'h0000_0001; req_address[31:0] = 32'h0000_0100; req_data[31:0] = 32'hDEAD_BEEF;
    req_valid = 2'b01; handler_ready = 1'b1;
    cycle();
    check("single_ack", 32'(req_ack), 1);
    check("single_data", data, 32'hDEAD_BEEF);
    check("single_send", 32'(send_en), 1);
    cycle();
    check("single_send_drop", 32'(send_en), 0);
    repeat (9) cycle();
    finished = 1'b1; cycle(); finished = 1'b0;
    check("single_idle", 32'(busy), 0);
    check("single_hold", address, 32'h0000_0100);
    // round-robin fairness from reset
    rst = 1'b1; cycle(); rst = 1'b0;
    keep = 1; set_words(0); set_words(1); req_valid = 2'b11;
    np = 0; done = 0; c0 = 0; c1 = 0;
    for (int t = 0; t < 200 && done < 4; t++) begin
      finished = (mode == 2 && waited == 2);
      cycle();
      if (req_ack != 0 && np < 8) begin order[np] = int'(grant_id); np++; end
      c0 += int'(req_ack[0]); c1 += int'(req_ack[1]);
      if (finished) done++;
    end
    finished = 1'b0; req_valid = '0; keep = 0;
    check("rr_done", done, 4);
    for (int i = 0; i < 4; i++) check("rr_order", order[i], i % 2);
    check("rr_ack0", c0, 2);
    check("rr_ack1", c1, 2);
    // handshake stall with input words changing after capture
    set_words(0); req_valid = 2'b01; handler_ready = 1'b0;
    cycle();
    held = data;
    set_words(0);
    for (int i = 0; i < 10; i++) begin
      check("stall_send", 32'(send_en), 1);
      check("stall_data", data, held);
      cycle();
    end
    handler_ready = 1'b1;
    check("stall_send_last", 32'(send_en), 1);
    cycle();
    check("stall_send_drop", 32'(send_en), 0);
    check("stall_data_after", data, held);
    finished = 1'b1; cycle(); finished = 1'b0;
    // watchdog
    set_words(1); req_valid = 2'b10;
    cycle(); cycle();
    for (int k = 1; k <= TO; k++) begin
      cycle();
      check("wd_pulse", 32'(timeout), 32'(k == TO));
    end
    check("wd_busy", 32'(busy), 0);
    set_words(0); set_words(1); req_valid = 2'b11;
    cycle();
    check("wd_next", 32'(grant_id), 0);
    cycle();
    finished = 1'b1; cycle(); finished = 1'b0;
    // collision of finished and expiry
    cycle(); cycle();
    check("col_grant", 32'(grant_id), 1);
    repeat (TO - 1) cycle();
    finished = 1'b1; cycle(); finished = 1'b0;
    check("col_timeout", 32'(timeout), 0);
    check("col_busy", 32'(busy), 0);
    cycle();
    check("col_quiet", 32'(timeout), 0);
    // reset mid-packet
    keep = 1; set_words(0); set_words(1); req_valid = 2'b11;
    cycle(); cycle(); cycle();
    check("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1; cycle();
    check("mid_ack", 32'(req_ack), 0);
    check("mid_status", status, 0);
    check("mid_address", address, 0);
    check("mid_data", data, 0);
    check("mid_send", 32'(send_en), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_grant", 32'(grant_id), 0);
    check("mid_timeout", 32'(timeout), 0);
    rst = 1'b0; cycle();
    check("mid_first_ack", 32'(req_ack), 1);
    check("mid_first_grant", 32'(grant_id), 0);
    keep = 0; req_valid[0] = 1'b0;
    // random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 9) < 3) begin set_words(i); req_valid[i] = 1'b1; end
      handler_ready = $urandom_range(0, 3) != 0;
      finished = !finished && $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 299) == 0;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
